// File: rtl/pcileech_led_ctl.sv
// pcileech_led_ctl: drives board status LEDs LD1 (PCIe) and LD2 (communication).
// Single-cycle activity pulses are stretched into visible, retriggerable indications.
// LD1 is overlaid on the PCIe link state.
// Optional power-on blink sequence: define PCILEECH_LED_PWRON_BLINK_EN to compile it in.
// Without it the FSM starts in RUN and pwron_done is tied high.
module pcileech_led_ctl #(
   parameter int unsigned STRETCH_CYCLES    = 2500000,
   parameter int unsigned BLINK_HALF_PERIOD = 16777216,
   parameter int unsigned PWRON_BLINKS      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic link_up,
   input  logic pcie_activity,
   input  logic com_activity,
   output logic led_ld1,
   output logic led_ld2,
   output logic pwron_done
);

   localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
   localparam logic [SW-1:0] StretchLoad = SW'(STRETCH_CYCLES);

   typedef enum logic {StPwron, StRun} state_e;

   logic [SW-1:0] cnt1_q, cnt1_d;
   logic [SW-1:0] cnt2_q, cnt2_d;
   logic          act1, act2;
   logic          led1_q, led1_d;
   logic          led2_q, led2_d;
   logic          phase_d;
   state_e        state_q;

   // Stretch channels: a pulse reloads the full length, otherwise count down to 0
   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (pcie_activity) begin
         cnt1_d = StretchLoad;
      end else if (cnt1_q != '0) begin
         cnt1_d = cnt1_q - SW'(1);
      end
      if (com_activity) begin
         cnt2_d = StretchLoad;
      end else if (cnt2_q != '0) begin
         cnt2_d = cnt2_q - SW'(1);
      end
   end

   assign act1 = (cnt1_q != '0);
   assign act2 = (cnt2_q != '0);

   // Stretch counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

`ifdef PCILEECH_LED_PWRON_BLINK_EN
   localparam int unsigned BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
   localparam int unsigned HW = $clog2(2 * PWRON_BLINKS + 1);
   localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF_PERIOD - 1);
   localparam logic [HW-1:0] HalfLast  = HW'(2 * PWRON_BLINKS - 1);

   logic [BW-1:0] blink_q, blink_d;
   logic [HW-1:0] half_q, half_d;
   logic          phase_q;
   state_e        state_d;

   // Power-on blink sequencer; RUN is terminal
   always_comb begin
      blink_d = blink_q;
      half_d  = half_q;
      phase_d = phase_q;
      state_d = state_q;
      if (state_q == StPwron) begin
         if (blink_q == BlinkLast) begin
            blink_d = '0;
            phase_d = ~phase_q;
            half_d  = half_q + HW'(1);
            if (half_q == HalfLast) begin
               state_d = StRun;
            end
         end else begin
            blink_d = blink_q + BW'(1);
         end
      end
   end

   // FSM and blink registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StPwron;
         blink_q <= '0;
         half_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
         half_q  <= half_d;
         phase_q <= phase_d;
      end
   end
`else
   assign state_q = StRun;
   assign phase_d = 1'b0;
`endif

   // LED next-state: blink pattern during power-on, activity/link overlay in RUN
   always_comb begin
      led1_d = link_up ^ act1;
      led2_d = act2;
      if (state_q == StPwron) begin
         // Track the next blink phase so the LEDs change on the wrap edge itself
         led1_d = phase_d;
         led2_d = phase_d;
      end
   end

   // LED output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led1_q <= 1'b0;
         led2_q <= 1'b0;
      end else begin
         led1_q <= led1_d;
         led2_q <= led2_d;
      end
   end

   assign led_ld1    = led1_q;
   assign led_ld2    = led2_q;
   assign pwron_done = (state_q == StRun);

endmodule

// File: tb/tb_pcileech_led_ctl.sv
// Directed self-checking bench for pcileech_led_ctl (STRETCH=4, HALF_PERIOD=8, BLINKS=2).
// Follows PCILEECH_LED_PWRON_BLINK_EN the same way the design does.
module tb_pcileech_led_ctl;

   localparam int unsigned SC  = 4;
   localparam int unsigned BHP = 8;
   localparam int unsigned PB  = 2;

`ifdef PCILEECH_LED_PWRON_BLINK_EN
   localparam logic PwronEn = 1'b1;
`else
   localparam logic PwronEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic link_up = 1'b0;
   logic pcie_activity = 1'b0;
   logic com_activity = 1'b0;
   logic led_ld1;
   logic led_ld2;
   logic pwron_done;

   int n_tests = 0;
   int n_fail = 0;

   pcileech_led_ctl #(
      .STRETCH_CYCLES   (SC),
      .BLINK_HALF_PERIOD(BHP),
      .PWRON_BLINKS     (PB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .link_up      (link_up),
      .pcie_activity(pcie_activity),
      .com_activity (com_activity),
      .led_ld1      (led_ld1),
      .led_ld2      (led_ld2),
      .pwron_done   (pwron_done)
   );

   always #5 clk = ~clk;

   // Advance one active edge and sample just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_ld1: got %b expected 0", led_ld1);
      end
      n_tests++;
      if (led_ld2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_ld2: got %b expected 0", led_ld2);
      end
      n_tests++;
      if (pwron_done !== ~PwronEn) begin
         n_fail++; $display("FAIL reset_pwron_done: got %b expected %b", pwron_done, ~PwronEn);
      end
   endtask

`ifdef PCILEECH_LED_PWRON_BLINK_EN
   task automatic test_power_on();
      logic exp;
      link_up = 1'b0;
      rst = 1'b0;
      n_tests++;
      if (led_ld1 !== 1'b0 || pwron_done !== 1'b0) begin
         n_fail++; $display("FAIL pwron_release: ld1=%b done=%b expected 0 0", led_ld1, pwron_done);
      end
      for (int k = 1; k <= 32; k++) begin
         // Activity during power-on must not disturb the blink pattern
         pcie_activity = (k == 3);
         tick();
         pcie_activity = 1'b0;
         exp = 1'((k / 8) % 2);
         n_tests++;
         if (led_ld1 !== exp || led_ld2 !== exp) begin
            n_fail++;
            $display("FAIL pwron_blink edge %0d: ld1=%b ld2=%b expected %b", k, led_ld1, led_ld2, exp);
         end
         n_tests++;
         if (pwron_done !== 1'(k == 32)) begin
            n_fail++;
            $display("FAIL pwron_done edge %0d: got %b expected %b", k, pwron_done, 1'(k == 32));
         end
      end
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0 || led_ld2 !== 1'b0 || pwron_done !== 1'b1) begin
         n_fail++;
         $display("FAIL pwron_to_run: ld1=%b ld2=%b done=%b expected 0 0 1",
                  led_ld1, led_ld2, pwron_done);
      end
   endtask
`else
   task automatic test_macro_off();
      rst = 1'b1;
      link_up = 1'b1;
      tick();
      n_tests++;
      if (pwron_done !== 1'b1) begin
         n_fail++; $display("FAIL macro_off_done_in_reset: got %b expected 1", pwron_done);
      end
      rst = 1'b0;
      n_tests++;
      if (led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL macro_off_release_ld1: got %b expected 0", led_ld1);
      end
      tick();
      n_tests++;
      if (led_ld1 !== 1'b1 || pwron_done !== 1'b1) begin
         n_fail++; $display("FAIL macro_off_first_edge: ld1=%b done=%b expected 1 1", led_ld1, pwron_done);
      end
      link_up = 1'b0;
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL macro_off_link_down: got %b expected 0", led_ld1);
      end
   endtask
`endif

   task automatic test_single_pulse();
      link_up = 1'b0;
      com_activity = 1'b1;
      tick();
      com_activity = 1'b0;
      n_tests++;
      if (led_ld2 !== 1'b0) begin
         n_fail++; $display("FAIL single_edge_n: got %b expected 0", led_ld2);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (led_ld2 !== 1'b1) begin
            n_fail++; $display("FAIL single_stretch N+%0d: got %b expected 1", i, led_ld2);
         end
      end
      tick();
      n_tests++;
      if (led_ld2 !== 1'b0 || led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL single_end: ld2=%b ld1=%b expected 0 0", led_ld2, led_ld1);
      end
   endtask

   task automatic test_retrigger(input int gap, input string name);
      link_up = 1'b0;
      pcie_activity = 1'b1;
      tick();
      pcie_activity = 1'b0;
      for (int i = 1; i <= gap + 4; i++) begin
         pcie_activity = (i == gap);
         tick();
         pcie_activity = 1'b0;
         n_tests++;
         if (led_ld1 !== 1'b1) begin
            n_fail++; $display("FAIL %s N+%0d: got %b expected 1", name, i, led_ld1);
         end
      end
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL %s_end: got %b expected 0", name, led_ld1);
      end
   endtask

   task automatic test_link_overlay();
      link_up = 1'b1;
      tick();
      n_tests++;
      if (led_ld1 !== 1'b1) begin
         n_fail++; $display("FAIL overlay_idle: got %b expected 1", led_ld1);
      end
      pcie_activity = 1'b1;
      tick();
      pcie_activity = 1'b0;
      n_tests++;
      if (led_ld1 !== 1'b1) begin
         n_fail++; $display("FAIL overlay_edge_n: got %b expected 1", led_ld1);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (led_ld1 !== 1'b0) begin
            n_fail++; $display("FAIL overlay_flicker N+%0d: got %b expected 0", i, led_ld1);
         end
      end
      tick();
      n_tests++;
      if (led_ld1 !== 1'b1) begin
         n_fail++; $display("FAIL overlay_restore: got %b expected 1", led_ld1);
      end
      link_up = 1'b0;
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL overlay_link_down: got %b expected 0", led_ld1);
      end
   endtask

   task automatic test_simultaneous();
      link_up = 1'b0;
      pcie_activity = 1'b1;
      com_activity = 1'b1;
      tick();
      pcie_activity = 1'b0;
      com_activity = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (led_ld1 !== 1'b1 || led_ld2 !== 1'b1) begin
            n_fail++; $display("FAIL simul N+%0d: ld1=%b ld2=%b expected 1 1", i, led_ld1, led_ld2);
         end
      end
      tick();
      n_tests++;
      if (led_ld1 !== 1'b0 || led_ld2 !== 1'b0) begin
         n_fail++; $display("FAIL simul_end: ld1=%b ld2=%b expected 0 0", led_ld1, led_ld2);
      end
   endtask

   task automatic test_reset_mid_stretch();
      link_up = 1'b0;
      com_activity = 1'b1;
      tick();
      com_activity = 1'b0;
      tick();
      tick();
      #2;
      n_tests++;
      if (led_ld2 !== 1'b1) begin
         n_fail++; $display("FAIL midreset_pre: got %b expected 1", led_ld2);
      end
      // Assert reset between edges; outputs must clear without a clock edge
      rst = 1'b1;
      #1;
      n_tests++;
      if (led_ld2 !== 1'b0 || led_ld1 !== 1'b0) begin
         n_fail++; $display("FAIL midreset_async: ld2=%b ld1=%b expected 0 0", led_ld2, led_ld1);
      end
      n_tests++;
      if (pwron_done !== ~PwronEn) begin
         n_fail++; $display("FAIL midreset_done: got %b expected %b", pwron_done, ~PwronEn);
      end
      tick();
      rst = 1'b0;
`ifdef PCILEECH_LED_PWRON_BLINK_EN
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (led_ld1 !== 1'(k == 8) || led_ld2 !== 1'(k == 8) || pwron_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_reblink edge %0d: ld1=%b ld2=%b done=%b expected %b %b 0",
                     k, led_ld1, led_ld2, pwron_done, 1'(k == 8), 1'(k == 8));
         end
      end
`else
      link_up = 1'b1;
      tick();
      n_tests++;
      if (led_ld1 !== 1'b1 || led_ld2 !== 1'b0 || pwron_done !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_run: ld1=%b ld2=%b done=%b expected 1 0 1",
                  led_ld1, led_ld2, pwron_done);
      end
      link_up = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
`ifdef PCILEECH_LED_PWRON_BLINK_EN
      test_power_on();
`else
      test_macro_off();
`endif
      test_single_pulse();
      test_retrigger(3, "retrigger");
      test_retrigger(4, "reload_at_zero");
      test_link_overlay();
      test_simultaneous();
      test_reset_mid_stretch();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
